// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared types and constants for the division control sequencer.
//   state_t   : sequencer states, one clock each
//   SH_*      : shift-control codes for the accumulator halves
//   ctrl_t    : datapath control word driven while in a given state
//   ctrl_of() : state -> control-word decode
package div_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_AH = 3'd1,
        LOAD_AL = 3'd2,
        CLR_AH  = 3'd3,
        SHIFT   = 3'd4,
        DIV     = 3'd5,
        FIX     = 3'd6,
        DONE    = 3'd7
    } state_t;

    localparam logic [1:0] SH_HOLD = 2'b00;
    localparam logic [1:0] SH_LEFT = 2'b10;
    localparam logic [1:0] SH_LOAD = 2'b11;

    typedef struct packed {
        logic       ah_reset;
        logic       ah_inen;
        logic [1:0] hs;
        logic [1:0] ls;
        logic       s_div;
        logic       acc_oen;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '{1'b0, 1'b0, SH_HOLD, SH_HOLD, 1'b0, 1'b0};

    // Control word for each state; anything not listed stays at CTRL_NONE.
    function automatic ctrl_t ctrl_of(input state_t st);
        ctrl_t c;
        c = CTRL_NONE;
        case (st)
            IDLE: begin
                c = CTRL_NONE;
            end
            LOAD_AH: begin
                c.ah_inen = 1'b1;
                c.hs      = SH_LOAD;
            end
            LOAD_AL: begin
                c.ls = SH_LOAD;
            end
            CLR_AH: begin
                c.ah_reset = 1'b1;
            end
            SHIFT: begin
                c.hs = SH_LEFT;
                c.ls = SH_LEFT;
            end
            DIV: begin
                c.hs    = SH_LOAD;
                c.s_div = 1'b1;
            end
            FIX: begin
                c.ls = SH_LEFT;
            end
            DONE: begin
                c.acc_oen = 1'b1;
            end
            default: begin
                c = CTRL_NONE;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/div_iter_cnt.sv
// div_iter_cnt: iteration counter for the shift/divide loop.
//   clk   : rising-edge clock
//   clr   : synchronous active-high reset, highest priority
//   clear : return count to zero (start of the loop)
//   inc   : advance by one (end of each divide step)
//   last  : count has reached N_BITS-1, i.e. the current step is the final one
module div_iter_cnt
    import div_seq_pkg::*;
#(
    parameter int N_BITS = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic clear,
    input  logic inc,
    output logic last
);

    // Wide enough to hold N_BITS itself, so the final increment never wraps.
    localparam int CNT_W = $clog2(N_BITS + 1);

    logic [CNT_W-1:0] cnt_r;

    // Count register: reset/clear to zero, otherwise step on inc.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign last = (cnt_r == CNT_W'(N_BITS - 1));

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: Moore FSM issuing the restoring-division control words to
// the accumulator/ALU datapath.
//   clk      : rising-edge clock
//   clr      : synchronous active-high reset, forces IDLE and all outputs 0
//   start    : request a division (only looked at in IDLE)
//   breg_in  : divisor, checked for zero when start is accepted
//   busy     : sequencer is not idle
//   done     : one-cycle completion pulse
//   err      : divide-by-zero flag, held until the next accepted start
//   ah_reset, ah_inen, hs, ls, s_div, acc_oen : datapath control word
// All outputs are registered and decoded from the state being entered, so
// they line up exactly with the state register.
module div_sequencer
    import div_seq_pkg::*;
#(
    parameter int N_BITS = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [N_BITS-1:0] breg_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ah_reset,
    output logic              ah_inen,
    output logic [1:0]        hs,
    output logic [1:0]        ls,
    output logic              s_div,
    output logic              acc_oen
);

    state_t state_r;
    state_t next_state_s;
    ctrl_t  ctrl_r;
    logic   busy_r;
    logic   done_r;
    logic   err_r;
    logic   err_next_s;
    logic   cnt_clear_s;
    logic   cnt_inc_s;
    logic   cnt_last_s;

    assign cnt_clear_s = (state_r == CLR_AH);
    assign cnt_inc_s   = (state_r == DIV);

    div_iter_cnt #(
        .N_BITS (N_BITS)
    ) u_iter_cnt (
        .clk   (clk),
        .clr   (clr),
        .clear (cnt_clear_s),
        .inc   (cnt_inc_s),
        .last  (cnt_last_s)
    );

    // Next-state and divide-by-zero flag decode.
    always_comb begin
        next_state_s = state_r;
        err_next_s   = err_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    // The divisor is judged once, here; later changes are ignored.
                    if (breg_in == {N_BITS{1'b0}}) begin
                        next_state_s = DONE;
                        err_next_s   = 1'b1;
                    end else begin
                        next_state_s = LOAD_AH;
                        err_next_s   = 1'b0;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD_AH: next_state_s = LOAD_AL;
            LOAD_AL: next_state_s = CLR_AH;
            CLR_AH:  next_state_s = SHIFT;
            SHIFT:   next_state_s = DIV;
            DIV: begin
                if (cnt_last_s) begin
                    next_state_s = FIX;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            FIX:     next_state_s = DONE;
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State and output registers; outputs follow the state being entered.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= IDLE;
            ctrl_r  <= CTRL_NONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            ctrl_r  <= ctrl_of(next_state_s);
            busy_r  <= (next_state_s != IDLE);
            done_r  <= (next_state_s == DONE);
            err_r   <= err_next_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;
    assign ah_reset = ctrl_r.ah_reset;
    assign ah_inen  = ctrl_r.ah_inen;
    assign hs       = ctrl_r.hs;
    assign ls       = ctrl_r.ls;
    assign s_div    = ctrl_r.s_div;
    assign acc_oen  = ctrl_r.acc_oen;

endmodule
